sync_fifo_ext: RTL and testbench

Single-clock, parametrised FIFO. It is the successor to the team's dual-clock FIFO, for use where producer and consumer share one clock.
- Uses all 2**ADDR_WIDTH entries; no slot is sacrificed to distinguish full from empty.
- Read mode is selectable: first-word-fall-through (FWFT) or standard registered read.
- Provides exact used/free counts, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits between stream producers and consumers inside one clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_sync_ram.sv | 52 +++++
 rtl/sync_fifo_ext.sv | 139 +++++++++++++
 tb/tb_sync_fifo_ext.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Depth/count widths are derived from the address width of each instance.
package fifo_pkg;

  localparam int STD_MODE  = 0;
  localparam int FWFT_MODE = 1;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so a completely full FIFO (DEPTH) is representable.
  function automatic int cnt_width_of(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit is_fwft(input int mode);
    return mode != STD_MODE;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage array: one write port, one read port exposing
// both a combinational word and a registered (load-enabled) word.
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata_comb,
  output logic [DATA_WIDTH-1:0] rdata_reg
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg_q;
  logic [DATA_WIDTH-1:0] rdata_reg_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_comb = mem_q[raddr];

  always_comb begin
    rdata_reg_d = rdata_reg_q;
    if (re) begin
      rdata_reg_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      rdata_reg_q <= '0;
    end else begin
      rdata_reg_q <= rdata_reg_d;
    end
  end

  assign rdata_reg = rdata_reg_q;

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO using every slot, with FWFT or registered read, exact
// used/free counts, programmable almost flags and sticky error flags.
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 4,
  parameter int          DATA_WIDTH    = 8,
  parameter int          FWFT          = FWFT_MODE,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  flush,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_W   = cnt_width_of(ADDR_WIDTH);
  localparam int DEPTH   = depth_of(ADDR_WIDTH);
  localparam bit FWFT_ON = is_fwft(FWFT);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      used_q, used_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rvalid_q, rvalid_d;

  logic                  full_w;
  logic                  empty_w;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata_comb;
  logic [DATA_WIDTH-1:0] ram_rdata_reg;

  assign full_w  = (used_q == CNT_W'(DEPTH));
  assign empty_w = (used_q == '0);

  // Flush swallows both requests so nothing reaches storage or the flags.
  assign wr_ok = we & ~full_w  & ~flush;
  assign rd_ok = re & ~empty_w & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    used_d      = used_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rvalid_d    = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      used_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   used_d = used_q + CNT_W'(1);
        2'b01:   used_d = used_q - CNT_W'(1);
        default: used_d = used_q;
      endcase
      if (we && full_w) begin
        overflow_d = 1'b1;
      end
      if (re && empty_w) begin
        underflow_d = 1'b1;
      end
      rvalid_d = rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // In FWFT mode the registered port tracks the presented head every cycle,
  // so rdata keeps its last visible word once the FIFO goes empty.
  assign ram_re = FWFT_ON ? ~empty_w : rd_ok;

  fifo_sync_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk        (clk),
    .resetb     (resetb),
    .we         (wr_ok),
    .waddr      (wr_ptr_q),
    .wdata      (wdata),
    .re         (ram_re),
    .raddr      (rd_ptr_q),
    .rdata_comb (ram_rdata_comb),
    .rdata_reg  (ram_rdata_reg)
  );

  assign rdata        = (FWFT_ON && !empty_w) ? ram_rdata_comb : ram_rdata_reg;
  assign rvalid       = FWFT_ON ? ~empty_w : rvalid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (32'(used_q) >= AFULL_THRESH);
  assign almost_empty = (32'(used_q) <= AEMPTY_THRESH);
  assign used_count   = used_q;
  assign free_count   = CNT_W'(DEPTH) - used_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: one FWFT and one standard-read instance driven by
// the same stimulus, checked against a queue model and constant vectors.
module tb_sync_fifo_ext;

  logic       clk;
  logic       resetb;
  logic       flush;
  logic       we;
  logic [7:0] wdata;
  logic       re;

  logic [7:0] fw_rdata, st_rdata;
  logic       fw_rvalid, st_rvalid;
  logic       fw_full, st_full, fw_empty, st_empty;
  logic       fw_af, st_af, fw_ae, st_ae;
  logic [4:0] fw_used, st_used, fw_free, st_free;
  logic       fw_ov, st_ov, fw_un, st_un;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mq[$];
  logic       m_ov, m_un, m_srv;
  logic [7:0] m_srd;

  sync_fifo_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1)) u_fw (
    .clk(clk), .resetb(resetb), .flush(flush), .we(we), .wdata(wdata), .re(re),
    .rdata(fw_rdata), .rvalid(fw_rvalid), .full(fw_full), .empty(fw_empty),
    .almost_full(fw_af), .almost_empty(fw_ae), .used_count(fw_used),
    .free_count(fw_free), .overflow(fw_ov), .underflow(fw_un)
  );

  sync_fifo_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0)) u_st (
    .clk(clk), .resetb(resetb), .flush(flush), .we(we), .wdata(wdata), .re(re),
    .rdata(st_rdata), .rvalid(st_rvalid), .full(st_full), .empty(st_empty),
    .almost_full(st_af), .almost_empty(st_ae), .used_count(st_used),
    .free_count(st_free), .overflow(st_ov), .underflow(st_un)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: a plain queue of stored words plus the sticky/read-side state.
  task automatic model_step(input logic rb, input logic fl, input logic w,
                            input logic [7:0] wd, input logic r);
    bit is_full, is_empty, wok, rok;
    is_full  = (mq.size() == 16);
    is_empty = (mq.size() == 0);
    wok = w && !is_full;
    rok = r && !is_empty;
    if (!rb) begin
      mq.delete(); m_ov = 0; m_un = 0; m_srv = 0; m_srd = 8'h00;
    end else if (fl) begin
      mq.delete(); m_ov = 0; m_un = 0; m_srv = 0;
    end else begin
      if (w && is_full) m_ov = 1;
      if (r && is_empty) m_un = 1;
      m_srv = rok;
      if (rok) m_srd = mq.pop_front();
      if (wok) mq.push_back(wd);
    end
  endtask

  task automatic step(input logic rb, input logic fl, input logic w,
                      input logic [7:0] wd, input logic r);
    resetb = rb; flush = fl; we = w; wdata = wd; re = r;
    @(posedge clk);
    model_step(rb, fl, w, wd, r);
    #1;
    resetb = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk($sformatf("%s fw_used", tag), 32'(fw_used), n);
    chk($sformatf("%s st_used", tag), 32'(st_used), n);
    chk($sformatf("%s fw_free", tag), 32'(fw_free), 16 - n);
    chk($sformatf("%s st_free", tag), 32'(st_free), 16 - n);
    chk($sformatf("%s fw_full", tag), 32'(fw_full), 32'(n == 16));
    chk($sformatf("%s st_full", tag), 32'(st_full), 32'(n == 16));
    chk($sformatf("%s fw_empty", tag), 32'(fw_empty), 32'(n == 0));
    chk($sformatf("%s st_empty", tag), 32'(st_empty), 32'(n == 0));
    chk($sformatf("%s fw_af", tag), 32'(fw_af), 32'(n >= 14));
    chk($sformatf("%s st_af", tag), 32'(st_af), 32'(n >= 14));
    chk($sformatf("%s fw_ae", tag), 32'(fw_ae), 32'(n <= 2));
    chk($sformatf("%s st_ae", tag), 32'(st_ae), 32'(n <= 2));
    chk($sformatf("%s fw_ov", tag), 32'(fw_ov), 32'(m_ov));
    chk($sformatf("%s st_ov", tag), 32'(st_ov), 32'(m_ov));
    chk($sformatf("%s fw_un", tag), 32'(fw_un), 32'(m_un));
    chk($sformatf("%s st_un", tag), 32'(st_un), 32'(m_un));
    chk($sformatf("%s fw_rvalid", tag), 32'(fw_rvalid), 32'(n != 0));
    chk($sformatf("%s st_rvalid", tag), 32'(st_rvalid), 32'(m_srv));
    chk($sformatf("%s st_rdata", tag), 32'(st_rdata), 32'(m_srd));
    if (n != 0) chk($sformatf("%s fw_rdata", tag), 32'(fw_rdata), 32'(mq[0]));
  endtask

  typedef struct {
    logic       rb, fl, w;
    logic [7:0] wd;
    logic       r;
    int         e_used;
    logic       e_ov, e_un, e_srv;
    logic [7:0] e_srd;
    logic       ck_head;
    logic [7:0] e_head;
  } vec_t;

  vec_t tbl[8];

  initial begin
    resetb = 1'b1; flush = 1'b0; we = 1'b0; wdata = 8'h00; re = 1'b0;

    //           rb    fl    w     wd     r    used ov    un    srv   srd    ck    head
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'h3C};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h11};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rb, tbl[i].fl, tbl[i].w, tbl[i].wd, tbl[i].r);
      chk($sformatf("vec%0d used", i), 32'(fw_used), tbl[i].e_used);
      chk($sformatf("vec%0d ov", i), 32'(fw_ov), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d un", i), 32'(st_un), 32'(tbl[i].e_un));
      chk($sformatf("vec%0d st_rvalid", i), 32'(st_rvalid), 32'(tbl[i].e_srv));
      chk($sformatf("vec%0d st_rdata", i), 32'(st_rdata), 32'(tbl[i].e_srd));
      if (tbl[i].ck_head) chk($sformatf("vec%0d fw_rdata", i), 32'(fw_rdata), 32'(tbl[i].e_head));
      check_all($sformatf("vec%0d", i));
    end

    // Fill 0x00..0x0F then drain in order.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
      check_all("fill");
      if (i == 12) chk("fill af_at13", 32'(fw_af), 0);
      if (i == 13) chk("fill af_at14", 32'(fw_af), 1);
    end
    chk("fill full", 32'(fw_full), 1);
    chk("fill used16", 32'(st_used), 16);
    chk("fill free0", 32'(fw_free), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain head", 32'(fw_rdata), i);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain st_rdata", 32'(st_rdata), i);
      check_all("drain");
    end
    chk("drain empty", 32'(fw_empty), 1);
    chk("drain no_err", 32'({fw_ov, fw_un, st_ov, st_un}), 0);

    // Overflow with a concurrent read, then underflow with a concurrent write.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    chk("ovf flag", 32'(fw_ov), 1);
    chk("ovf used15", 32'(fw_used), 15);
    chk("ovf st_rdata", 32'(st_rdata), 8'h40);
    check_all("ovf");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1);
    chk("unf flag", 32'(st_un), 1);
    chk("unf used1", 32'(st_used), 1);
    chk("unf ovf_sticky", 32'(st_ov), 1);
    chk("unf head", 32'(fw_rdata), 8'h5A);
    check_all("unf");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("sticky ov", 32'(fw_ov), 1);
    chk("sticky un", 32'(fw_un), 1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("flush clears", 32'({fw_ov, fw_un}), 0);

    // Standard-mode read latency.
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    chk("std idle rvalid", 32'(st_rvalid), 0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("std rd1", 32'({st_rvalid, st_rdata}), {1'b1, 8'h11});
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("std rd2", 32'({st_rvalid, st_rdata}), {1'b1, 8'h22});
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("std after", 32'({st_rvalid, st_rdata}), {1'b0, 8'h22});
    check_all("std");

    // Wrap-around: 40 write/read pairs.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
      chk("wrap head", 32'(fw_rdata), 8'h80 + i);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("wrap st", 32'(st_rdata), 8'h80 + i);
      check_all("wrap");
    end

    // Flush at count 9 with a write pending.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 8'(i + 1), 1'b0);
    chk("pre_flush used9", 32'(fw_used), 9);
    step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
    chk("flush used0", 32'(fw_used), 0);
    chk("flush empty", 32'(st_empty), 1);
    check_all("flush");
    step(1'b1, 1'b0, 1'b1, 8'h42, 1'b0);
    chk("flush not_stored", 32'(fw_rdata), 8'h42);
    chk("flush used1", 32'(fw_used), 1);

    // Reset wins over flush and clears rdata.
    step(1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
    chk("rst fw_rdata", 32'(fw_rdata), 0);
    chk("rst st_rdata", 32'(st_rdata), 0);
    chk("rst flags", 32'({fw_empty, fw_full, fw_ae, fw_af, st_rvalid}), 5'b10100);
    check_all("rst");

    // Randomized traffic in write-heavy, read-heavy and balanced phases.
    for (int c = 0; c < 2400; c++) begin
      int ph;
      int pw;
      logic w, r, fl, rb;
      ph = (c / 200) % 3;
      pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      w  = ($urandom_range(99) < pw);
      r  = ($urandom_range(99) < (100 - pw));
      fl = ($urandom_range(127) == 0);
      rb = ($urandom_range(511) != 0);
      step(rb, fl, w, 8'($urandom_range(255)), r);
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
